// File: rtl/eq_axil_cfg_regs.sv
// AXI-Lite register bank for the equaliser: control, sticky status and per-band coefficients.
// Optional byte-lane write strobes are enabled by defining EQ_AXIL_WSTRB_EN.
module eq_axil_cfg_regs #(
    parameter int C_S00_AXIL_DATA_WIDTH = 32,
    parameter int C_S00_AXIL_ADDR_WIDTH = 7,
    parameter int NUM_BANDS             = 10,
    parameter int AMPLIFICATION_WIDTH   = 24,
    parameter int BOUNDARIES_WIDTH      = 11
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [C_S00_AXIL_ADDR_WIDTH-1:0]              s00_axil_awaddr,
    input  logic                                          s00_axil_awvalid,
    output logic                                          s00_axil_awready,
    input  logic [C_S00_AXIL_DATA_WIDTH-1:0]              s00_axil_wdata,
`ifdef EQ_AXIL_WSTRB_EN
    input  logic [C_S00_AXIL_DATA_WIDTH/8-1:0]            s00_axil_wstrb,
`endif
    input  logic                                          s00_axil_wvalid,
    output logic                                          s00_axil_wready,
    output logic [1:0]                                    s00_axil_bresp,
    output logic                                          s00_axil_bvalid,
    input  logic                                          s00_axil_bready,
    input  logic [C_S00_AXIL_ADDR_WIDTH-1:0]              s00_axil_araddr,
    input  logic                                          s00_axil_arvalid,
    output logic                                          s00_axil_arready,
    output logic [C_S00_AXIL_DATA_WIDTH-1:0]              s00_axil_rdata,
    output logic [1:0]                                    s00_axil_rresp,
    output logic                                          s00_axil_rvalid,
    input  logic                                          s00_axil_rready,
    output logic [NUM_BANDS*AMPLIFICATION_WIDTH-1:0]      amplification_o,
    output logic [NUM_BANDS*BOUNDARIES_WIDTH-1:0]         boundaries_o,
    output logic                                          enable_o,
    output logic                                          start_o,
    input  logic                                          done_i
);
    localparam int DW       = C_S00_AXIL_DATA_WIDTH;
    localparam int IW       = C_S00_AXIL_ADDR_WIDTH - 2;
    localparam int AMW      = AMPLIFICATION_WIDTH;
    localparam int BNW      = BOUNDARIES_WIDTH;
    localparam int AMP_BASE = 2;
    localparam int BND_BASE = NUM_BANDS + 2;
    localparam int MAP_END  = 2 * NUM_BANDS + 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    genvar gi;

    logic          aw_full_reg, aw_full_next;
    logic          w_full_reg, w_full_next;
    logic [IW-1:0] aw_idx_reg;
    logic [DW-1:0] w_data_reg;
    logic [DW-1:0] w_mask;
    logic          aw_rdy_reg, w_rdy_reg, ar_rdy_reg;
    logic          bvalid_reg, bvalid_next;
    logic [1:0]    bresp_reg;
    logic          rvalid_reg, rvalid_next;
    logic [1:0]    rresp_reg, rresp_next;
    logic [DW-1:0] rdata_reg, rdata_next;
    logic          enable_reg, done_reg, start_reg;
    logic          aw_hs, w_hs, ar_hs, commit;
    logic          ctrl_wr, status_wr, wr_mapped;
    logic [IW-1:0] ar_idx;
    logic          unused_bits;

`ifdef EQ_AXIL_WSTRB_EN
    logic [DW/8-1:0] w_strb_reg;
    for (gi = 0; gi < DW / 8; gi++) begin : g_mask
        assign w_mask[gi*8 +: 8] = {8{w_strb_reg[gi]}};
    end
`else
    assign w_mask = '1;
`endif

    assign aw_hs     = s00_axil_awvalid && aw_rdy_reg;
    assign w_hs      = s00_axil_wvalid && w_rdy_reg;
    assign ar_hs     = s00_axil_arvalid && ar_rdy_reg;
    assign commit    = aw_full_reg && w_full_reg;
    assign ctrl_wr   = commit && (aw_idx_reg == IW'(0));
    assign status_wr = commit && (aw_idx_reg == IW'(1));
    assign wr_mapped = int'(aw_idx_reg) < MAP_END;
    assign ar_idx    = s00_axil_araddr[C_S00_AXIL_ADDR_WIDTH-1:2];

    assign aw_full_next = aw_hs || (aw_full_reg && !commit);
    assign w_full_next  = w_hs || (w_full_reg && !commit);
    assign bvalid_next  = commit || (bvalid_reg && !s00_axil_bready);
    assign rvalid_next  = ar_hs || (rvalid_reg && !s00_axil_rready);

    // Readies are registered from next-state so they are low during reset and have no input-to-output path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            aw_idx_reg  <= '0;
            w_data_reg  <= '0;
`ifdef EQ_AXIL_WSTRB_EN
            w_strb_reg  <= '0;
`endif
            aw_rdy_reg  <= 1'b0;
            w_rdy_reg   <= 1'b0;
            ar_rdy_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
            enable_reg  <= 1'b0;
            done_reg    <= 1'b0;
            start_reg   <= 1'b0;
        end else begin
            aw_full_reg <= aw_full_next;
            w_full_reg  <= w_full_next;
            aw_rdy_reg  <= !aw_full_next && !bvalid_next;
            w_rdy_reg   <= !w_full_next && !bvalid_next;
            ar_rdy_reg  <= !rvalid_next;
            bvalid_reg  <= bvalid_next;
            rvalid_reg  <= rvalid_next;
            if (aw_hs) begin
                aw_idx_reg <= s00_axil_awaddr[C_S00_AXIL_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_data_reg <= s00_axil_wdata;
`ifdef EQ_AXIL_WSTRB_EN
                w_strb_reg <= s00_axil_wstrb;
`endif
            end
            if (commit) begin
                bresp_reg <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end
            if (ar_hs) begin
                rdata_reg <= rdata_next;
                rresp_reg <= rresp_next;
            end
            start_reg <= ctrl_wr && w_mask[0] && w_data_reg[0];
            if (ctrl_wr && w_mask[1]) begin
                enable_reg <= w_data_reg[1];
            end
            // A done indication in the same cycle as a clear must not be lost.
            if (done_i) begin
                done_reg <= 1'b1;
            end else if (status_wr && w_mask[0] && w_data_reg[0]) begin
                done_reg <= 1'b0;
            end
        end
    end

    for (gi = 0; gi < NUM_BANDS; gi++) begin : g_band
        logic [AMW-1:0] amp_reg;
        logic [BNW-1:0] bnd_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                amp_reg <= '0;
                bnd_reg <= '0;
            end else if (commit) begin
                if (aw_idx_reg == IW'(AMP_BASE + gi)) begin
                    amp_reg <= AMW'((w_data_reg & w_mask) | (DW'(amp_reg) & ~w_mask));
                end
                if (aw_idx_reg == IW'(BND_BASE + gi)) begin
                    bnd_reg <= BNW'((w_data_reg & w_mask) | (DW'(bnd_reg) & ~w_mask));
                end
            end
        end

        assign amplification_o[gi*AMW +: AMW] = amp_reg;
        assign boundaries_o[gi*BNW +: BNW]    = bnd_reg;
    end

    always_comb begin
        rdata_next = '0;
        rresp_next = RESP_OKAY;
        if (ar_idx == IW'(0)) begin
            rdata_next[1] = enable_reg;
        end else if (ar_idx == IW'(1)) begin
            rdata_next[0] = done_reg;
        end else if (int'(ar_idx) >= MAP_END) begin
            rresp_next = RESP_SLVERR;
        end
        for (int i = 0; i < NUM_BANDS; i++) begin
            if (ar_idx == IW'(AMP_BASE + i)) begin
                rdata_next[AMW-1:0] = amplification_o[i*AMW +: AMW];
            end
            if (ar_idx == IW'(BND_BASE + i)) begin
                rdata_next[BNW-1:0] = boundaries_o[i*BNW +: BNW];
            end
        end
    end

    assign unused_bits = ^{s00_axil_awaddr[1:0], s00_axil_araddr[1:0], w_data_reg, w_mask};

    assign s00_axil_awready = aw_rdy_reg;
    assign s00_axil_wready  = w_rdy_reg;
    assign s00_axil_arready = ar_rdy_reg;
    assign s00_axil_bvalid  = bvalid_reg;
    assign s00_axil_bresp   = bresp_reg;
    assign s00_axil_rvalid  = rvalid_reg;
    assign s00_axil_rresp   = rresp_reg;
    assign s00_axil_rdata   = rdata_reg;
    assign enable_o         = enable_reg;
    assign start_o          = start_reg;
endmodule

// File: tb/tb_eq_axil_cfg_regs.sv
// Self-checking bench for eq_axil_cfg_regs: vector table plus hand sequences, scoreboard queues for responses.
module tb_eq_axil_cfg_regs;
    localparam int DW  = 32;
    localparam int AW  = 7;
    localparam int NB  = 10;
    localparam int AMW = 24;
    localparam int BNW = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [AW-1:0]     awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DW-1:0]     wdata = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b1;
    logic [AW-1:0]     araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b1;
    logic [NB*AMW-1:0] amp;
    logic [NB*BNW-1:0] bnd;
    logic              enable_o;
    logic              start_o;
    logic              done_i = 1'b0;
`ifdef EQ_AXIL_WSTRB_EN
    logic [DW/8-1:0]   wstrb = '1;
`endif

    eq_axil_cfg_regs dut (
        .clk              (clk),
        .rst              (rst),
        .s00_axil_awaddr  (awaddr),
        .s00_axil_awvalid (awvalid),
        .s00_axil_awready (awready),
        .s00_axil_wdata   (wdata),
`ifdef EQ_AXIL_WSTRB_EN
        .s00_axil_wstrb   (wstrb),
`endif
        .s00_axil_wvalid  (wvalid),
        .s00_axil_wready  (wready),
        .s00_axil_bresp   (bresp),
        .s00_axil_bvalid  (bvalid),
        .s00_axil_bready  (bready),
        .s00_axil_araddr  (araddr),
        .s00_axil_arvalid (arvalid),
        .s00_axil_arready (arready),
        .s00_axil_rdata   (rdata),
        .s00_axil_rresp   (rresp),
        .s00_axil_rvalid  (rvalid),
        .s00_axil_rready  (rready),
        .amplification_o  (amp),
        .boundaries_o     (bnd),
        .enable_o         (enable_o),
        .start_o          (start_o),
        .done_i           (done_i)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int start_cnt = 0;
    int bhs_cnt = 0;

    logic [1:0]  wr_q[$];
    logic [33:0] rd_q[$];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    bresp;
        logic [DW-1:0] rdata;
        logic [1:0]    rresp;
    } vec_t;
    vec_t vecs[9];

    always @(negedge clk) begin
        if (start_o) start_cnt++;
        if (bvalid && bready) bhs_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [1:0] exp_resp, input int w_delay);
        int cyc;
        logic aw_go, w_go;
        logic [1:0] exp_b;
        wr_q.push_back(exp_resp);
        awaddr  = addr;
        awvalid = 1'b1;
        wdata   = data;
        wvalid  = (w_delay == 0);
        cyc = 0;
        while ((awvalid || wvalid || cyc < w_delay) && cyc < 40) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            if (!awvalid && cyc > 0 && cyc <= w_delay) chk("awready_low_while_aw_held", awready, 0);
            @(posedge clk);
            #1;
            if (aw_go) awvalid = 1'b0;
            if (w_go) wvalid = 1'b0;
            cyc++;
            if (w_delay > 0 && cyc == w_delay) wvalid = 1'b1;
        end
        chk("aw_w_handshake_done", {awvalid, wvalid}, 0);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        cyc = 0;
        while (!bvalid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("bvalid_latency", cyc, 1);
        exp_b = wr_q.pop_front();
        chk("bresp", bresp, exp_b);
        $display("WR addr=0x%02h data=0x%08h bresp=%02b", addr, data, bresp);
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data,
                            input logic [1:0] exp_resp);
        int cyc;
        logic [33:0] exp_r;
        rd_q.push_back({exp_data, exp_resp});
        araddr  = addr;
        arvalid = 1'b1;
        cyc = 0;
        while (!arready && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("arready_seen", arready, 1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rvalid_latency", cyc, 0);
        exp_r = rd_q.pop_front();
        chk("rdata", rdata, exp_r[33:2]);
        chk("rresp", rresp, exp_r[1:0]);
        $display("RD addr=0x%02h rdata=0x%08h rresp=%02b", addr, rdata, rresp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s0, b0;

        vecs[0] = '{7'h14, 32'h00ABCDEF, 2'b00, 32'h00ABCDEF, 2'b00};
        vecs[1] = '{7'h08, 32'hFFFFFFFF, 2'b00, 32'h00FFFFFF, 2'b00};
        vecs[2] = '{7'h2C, 32'h12345678, 2'b00, 32'h00345678, 2'b00};
        vecs[3] = '{7'h30, 32'h0000F555, 2'b00, 32'h00000555, 2'b00};
        vecs[4] = '{7'h54, 32'h00000123, 2'b00, 32'h00000123, 2'b00};
        vecs[5] = '{7'h7C, 32'hDEADBEEF, 2'b10, 32'h00000000, 2'b10};
        vecs[6] = '{7'h58, 32'h00000001, 2'b10, 32'h00000000, 2'b10};
        vecs[7] = '{7'h04, 32'h00000000, 2'b00, 32'h00000000, 2'b00};
        vecs[8] = '{7'h17, 32'h000000AA, 2'b00, 32'h000000AA, 2'b00};

        #3;
        chk("reset_handshake_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, enable_o, start_o}, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_buses", {|amp, |bnd}, 0);
        idle(2);
        rst = 1'b1;
        idle(2);
        chk("ready_after_reset", {awready, wready, arready}, 3'b111);

        for (int i = 0; i < 9; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].bresp, 0);
            axi_read(vecs[i].addr, vecs[i].rdata, vecs[i].rresp);
        end
        chk("amp_band3", amp[3*AMW +: AMW], 24'h0000AA);
        chk("amp_band0", amp[0*AMW +: AMW], 24'hFFFFFF);
        chk("amp_band9", amp[9*AMW +: AMW], 24'h345678);
        chk("bnd_band9", bnd[9*BNW +: BNW], 11'h123);
        chk("amp_band1_untouched", amp[1*AMW +: AMW], 0);

        // AW leads W by three cycles
        b0 = bhs_cnt;
        axi_write(7'h30, 32'h000007FF, 2'b00, 3);
        idle(2);
        chk("single_bvalid", bhs_cnt - b0, 1);
        chk("bnd_band0", bnd[0 +: BNW], 11'h7FF);

        // CTRL start/enable
        s0 = start_cnt;
        axi_write(7'h00, 32'h3, 2'b00, 0);
        idle(3);
        chk("start_pulse_once", start_cnt - s0, 1);
        chk("enable_set", enable_o, 1);
        axi_read(7'h00, 32'h2, 2'b00);
        s0 = start_cnt;
        axi_write(7'h00, 32'h1, 2'b00, 0);
        axi_write(7'h00, 32'h1, 2'b00, 0);
        idle(3);
        chk("start_back_to_back", start_cnt - s0, 2);
        chk("enable_cleared", enable_o, 0);

        // done sticky bit
        axi_read(7'h04, 32'h0, 2'b00);
        done_i = 1'b1;
        idle(1);
        done_i = 1'b0;
        idle(2);
        axi_read(7'h04, 32'h1, 2'b00);
        done_i = 1'b1;
        axi_write(7'h04, 32'h1, 2'b00, 0);
        done_i = 1'b0;
        axi_read(7'h04, 32'h1, 2'b00);
        axi_write(7'h04, 32'h1, 2'b00, 0);
        axi_read(7'h04, 32'h0, 2'b00);

        // write response back-pressure
        bready = 1'b0;
        b0 = bhs_cnt;
        axi_write(7'h20, 32'h11, 2'b00, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bready_stall", {bvalid, awready, wready}, 3'b100);
            idle(1);
        end
        bready = 1'b1;
        idle(1);
        chk("stall_single_handshake", bhs_cnt - b0, 1);
        axi_write(7'h24, 32'h22, 2'b00, 0);
        axi_read(7'h24, 32'h22, 2'b00);
        axi_read(7'h20, 32'h11, 2'b00);

        // reset with the AW slot full
        s0 = start_cnt;
        axi_write(7'h00, 32'h2, 2'b00, 0);
        idle(3);
        chk("enable_no_start", {enable_o, 8'(start_cnt - s0)}, 9'h100);
        awaddr  = 7'h1C;
        awvalid = 1'b1;
        idle(1);
        awvalid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_handshake_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, enable_o, start_o}, 0);
        chk("midreset_rdata", rdata, 0);
        chk("midreset_buses", {|amp, |bnd}, 0);
        idle(2);
        rst = 1'b1;
        idle(2);
        axi_write(7'h18, 32'h005A5A5A, 2'b00, 0);
        axi_read(7'h18, 32'h005A5A5A, 2'b00);
        axi_read(7'h1C, 32'h0, 2'b00);
        chk("amp_band4_after_reset", amp[4*AMW +: AMW], 24'h5A5A5A);
        chk("amp_band5_after_reset", amp[5*AMW +: AMW], 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
